// File: rtl/emib_write_arb_if.sv
// rtl/emib_write_arb_if.sv - source/RAM/status bundle for the EMIB write arbiter
interface emib_write_arb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0]        i_req;
    logic [NUM_CH-1:0]        i_err;
    logic [NUM_CH*ADDR_W-1:0] i_base_addr;
    logic [NUM_CH*ADDR_W-1:0] i_len;
    logic [NUM_CH*DATA_W-1:0] i_src_data;
    logic [NUM_CH-1:0]        o_src_rd;
    logic [ADDR_W-1:0]        o_src_addr;
    logic                     o_ram_we;
    logic [ADDR_W-1:0]        o_ram_addr;
    logic [DATA_W-1:0]        o_ram_data;
    logic [NUM_CH-1:0]        o_done;
    logic [NUM_CH-1:0]        o_error;
    logic                     o_busy;

    modport slave (
        input  i_req, i_err, i_base_addr, i_len, i_src_data,
        output o_src_rd, o_src_addr, o_ram_we, o_ram_addr, o_ram_data,
        output o_done, o_error, o_busy
    );

    modport master (
        output i_req, i_err, i_base_addr, i_len, i_src_data,
        input  o_src_rd, o_src_addr, o_ram_we, o_ram_addr, o_ram_data,
        input  o_done, o_error, o_busy
    );
endinterface

// File: rtl/emib_write_arb.sv
// rtl/emib_write_arb.sv - round-robin multi-channel block copier into the EMIB RAM
module emib_write_arb #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 10,
    parameter int NUM_CH     = 2,
    parameter int RAM_DEPTH  = 1024,
    parameter int GAP_CYCLES = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    emib_write_arb_if.slave  bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(RAM_DEPTH);
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_BURST, S_DRAIN, S_DONE, S_ERROR, S_GAP
    } state_t;

    state_t              state_q;
    logic [CH_W-1:0]     rr_ptr_q;
    logic [CH_W-1:0]     ch_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   len_q;
    logic                drain_q;
    logic [GAP_W-1:0]    gap_q;
    logic                rd_d1_q;
    logic [ADDR_W-1:0]   rd_k_q;
    logic [NUM_CH-1:0]   src_rd_q;
    logic [ADDR_W-1:0]   src_addr_q;
    logic                ram_we_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_data_q;
    logic [NUM_CH-1:0]   done_q;
    logic [NUM_CH-1:0]   error_q;
    logic                busy_q;

    logic                grant_found_d;
    logic [CH_W-1:0]     grant_ch_d;
    logic [CH_W-1:0]     rr_ptr_d;
    logic [ADDR_W-1:0]   grant_base_d;
    logic [ADDR_W-1:0]   grant_len_d;
    logic                cur_err_d;
    logic [DATA_W-1:0]   cur_data_d;
    logic [NUM_CH-1:0]   ch_onehot_d;
    logic [ADDR_W:0]     end_sum_d;
    logic                bad_d;

    assign bus.o_src_rd   = src_rd_q;
    assign bus.o_src_addr = src_addr_q;
    assign bus.o_ram_we   = ram_we_q;
    assign bus.o_ram_addr = ram_addr_q;
    assign bus.o_ram_data = ram_data_q;
    assign bus.o_done     = done_q;
    assign bus.o_error    = error_q;
    assign bus.o_busy     = busy_q;

    // Round-robin pick: first requester at or above rr_ptr, else first below it.
    always_comb begin
        grant_found_d = 1'b0;
        grant_ch_d    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!grant_found_d && bus.i_req[c] && (c >= int'(rr_ptr_q))) begin
                grant_found_d = 1'b1;
                grant_ch_d    = CH_W'(c);
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (!grant_found_d && bus.i_req[c] && (c < int'(rr_ptr_q))) begin
                grant_found_d = 1'b1;
                grant_ch_d    = CH_W'(c);
            end
        end
        rr_ptr_d = (grant_ch_d == CH_LAST) ? '0 : grant_ch_d + 1'b1;
    end

    // Per-channel selection for the candidate grant and for the latched channel.
    always_comb begin
        grant_base_d = '0;
        grant_len_d  = '0;
        cur_err_d    = 1'b0;
        cur_data_d   = '0;
        ch_onehot_d  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant_ch_d == CH_W'(c)) begin
                grant_base_d = bus.i_base_addr[c*ADDR_W +: ADDR_W];
                grant_len_d  = bus.i_len[c*ADDR_W +: ADDR_W];
            end
            if (ch_q == CH_W'(c)) begin
                cur_err_d      = bus.i_err[c];
                cur_data_d     = bus.i_src_data[c*DATA_W +: DATA_W];
                ch_onehot_d[c] = 1'b1;
            end
        end
        // One extra bit so a range ending past the top cannot wrap back in bounds.
        end_sum_d = {1'b0, base_q} + {1'b0, len_q};
        bad_d     = cur_err_d || (len_q == '0) || (end_sum_d > DEPTH_L);
    end

    // Control FSM plus the two-stage read-to-write pipeline, all outputs registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            ch_q       <= '0;
            base_q     <= '0;
            len_q      <= '0;
            drain_q    <= 1'b0;
            gap_q      <= '0;
            rd_d1_q    <= 1'b0;
            rd_k_q     <= '0;
            src_rd_q   <= '0;
            src_addr_q <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            done_q     <= '0;
            error_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            done_q   <= '0;
            error_q  <= '0;
            rd_d1_q  <= (src_rd_q != '0);
            rd_k_q   <= src_addr_q;
            ram_we_q <= rd_d1_q;
            if (rd_d1_q) begin
                ram_addr_q <= base_q + rd_k_q;
                ram_data_q <= cur_data_d;
            end
            case (state_q)
                S_IDLE: begin
                    if (grant_found_d) begin
                        ch_q     <= grant_ch_d;
                        base_q   <= grant_base_d;
                        len_q    <= grant_len_d;
                        rr_ptr_q <= rr_ptr_d;
                        busy_q   <= 1'b1;
                        state_q  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (bad_d) begin
                        error_q <= ch_onehot_d;
                        state_q <= S_ERROR;
                    end else begin
                        src_rd_q   <= ch_onehot_d;
                        src_addr_q <= '0;
                        state_q    <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (src_addr_q == len_q - 1'b1) begin
                        src_rd_q   <= '0;
                        src_addr_q <= '0;
                        drain_q    <= 1'b0;
                        state_q    <= S_DRAIN;
                    end else begin
                        src_addr_q <= src_addr_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_q) begin
                        done_q  <= ch_onehot_d;
                        state_q <= S_DONE;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                S_DONE, S_ERROR: begin
                    if (GAP_CYCLES == 0) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        gap_q   <= '0;
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/emib_write_arb.md
# emib_write_arb

Parametrised multi-channel EMIB write engine. Arbitrates round-robin among NUM_CH requesting sources (management block, OPC configuration, further channels), copies each granted source's block of words into the EMIB RAM at that channel's base address, and reports per-channel done or error. It sits between the source buffers and the EMIB RAM write port. Relative to the single-source writer it adds channel generalisation, fairness, bounds checking and a configurable inter-transfer gap.

## Interface
- DATA_W, 16, RAM word width
- ADDR_W, 10, RAM and length address width
- NUM_CH, 2, number of source channels (1..8)
- RAM_DEPTH, 1024, RAM words; legal addresses 0..RAM_DEPTH-1
- GAP_CYCLES, 3, idle cycles after each done/error before next grant (0 allowed)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_req  in  NUM_CH  per-channel transfer request, level, held until done/error
- i_err  in  NUM_CH  per-channel upstream error flag, sampled in CHECK
- i_base_addr  in  NUM_CH*ADDR_W  per-channel RAM base, channel c at [c*ADDR_W +: ADDR_W]
- i_len  in  NUM_CH*ADDR_W  per-channel word count
- i_src_data  in  NUM_CH*DATA_W  per-channel source read data, valid 1 cycle after o_src_rd
- o_src_rd  out  NUM_CH  one-hot source read strobe
- o_src_addr  out  ADDR_W  source word index (0-based)
- o_ram_we  out  1  RAM write enable
- o_ram_addr  out  ADDR_W  RAM write address
- o_ram_data  out  DATA_W  RAM write data
- o_done  out  NUM_CH  one-cycle done pulse for granted channel
- o_error  out  NUM_CH  one-cycle error pulse for granted channel
- o_busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, CHECK, BURST, DRAIN, DONE, ERROR, GAP.
- IDLE: if any i_req, grant the first requesting channel at or after rr_ptr (wrapping); latch channel index, base, len; rr_ptr <= granted+1 mod NUM_CH; go CHECK.
- CHECK (1 cycle): ERROR if i_err[ch], len==0, or base+len > RAM_DEPTH (computed in ADDR_W+1 bits, no wrap). Otherwise BURST with word counter k=0.
- BURST: o_src_rd[ch]=1, o_src_addr=k each cycle, k increments; after k=len-1 issued go DRAIN.
- Write pipeline: i_src_data[ch] sampled the cycle after o_src_rd, registered onto o_ram_data with o_ram_addr=base+k, o_ram_we=1. Write of word k is visible 2 cycles after its read strobe.
- DRAIN (2 cycles): no reads; last writes retire. Then DONE.
- DONE / ERROR (1 cycle each): pulse o_done[ch] or o_error[ch]; go GAP, or IDLE if GAP_CYCLES==0.
- GAP: GAP_CYCLES cycles, no grants, then IDLE.
- ERROR path never asserts o_ram_we or o_src_rd.
- i_req deasserting mid-transfer does not abort; the transfer completes. Per-channel inputs other than i_src_data are used only as latched in IDLE/CHECK, except i_err, which is read in CHECK.
- Only one channel is active at a time; o_src_rd is one-hot or zero.

## Timing
- Reset (async assert, synchronous release effect): state IDLE, rr_ptr 0, all outputs 0 (o_ram_we, o_ram_addr, o_ram_data, o_src_rd, o_src_addr, o_done, o_error, o_busy).
- Reset mid-burst aborts immediately: no done/error pulse, no further writes.
- Request seen in IDLE at cycle 0 -> CHECK cycle 1 -> first o_src_rd cycle 2 -> first o_ram_we cycle 4.
- For len=L, the last o_ram_we is at cycle L+3, o_done at cycle L+4, IDLE reachable at cycle L+5+GAP_CYCLES.
- Error case: o_error at cycle 2.
- o_ram_we is high for exactly L consecutive cycles per good transfer, with addresses base..base+L-1 ascending.
- Simultaneous requests: one grant per IDLE visit; the other channel waits and is served next because of the rr_ptr rotation.
- Boundary: base+len == RAM_DEPTH is legal (last address RAM_DEPTH-1); base+len == RAM_DEPTH+1 is an error.

## Test plan
- Ch0 base 0x010, len 4, source data 0xA0..0xA3 -> writes 0x010..0x013 = A0..A3 on cycles 4..7, o_done[0] at cycle 8, o_busy low after GAP.
- Ch0 and ch1 request together, rr_ptr 0 -> ch0 served fully, then after 3 gap cycles ch1 granted; a repeated simultaneous request next grants ch0 again only after ch1 (alternation).
- Ch1 with i_err=1, len 8 -> o_error[1] at cycle 2, zero o_ram_we and o_src_rd cycles.
- Base 1020, len 4 (RAM_DEPTH 1024) -> good transfer, last address 1023; base 1021, len 4 -> o_error, no writes; len 0 -> o_error.
- Reset asserted during BURST of len 16 after 5 writes -> outputs 0 asynchronously, no done pulse; after release a new ch0 request is granted normally from rr_ptr 0.
- GAP_CYCLES=0 build, back-to-back ch0 requests -> next CHECK begins the cycle after IDLE following o_done.
